// File: rtl/ghash_block_formatter.sv
// rtl/ghash_block_formatter.sv - GCM block sequencer feeding AAD, ciphertext and the length block to GHASH
module ghash_block_formatter #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] aad_bytes,
    input  logic [LEN_W-1:0] ct_bytes,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ghash_start,
    output logic [127:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    // Counter is at least 6 bits wide so the "more than one word left" test works for tiny LEN_W.
    localparam int CW = (LEN_W < 6) ? 6 : LEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AAD,
        S_CT,
        S_LEN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [LEN_W-1:0] aad_len;
    logic [LEN_W-1:0] ct_len;
    logic [CW-1:0]    remaining;
    logic             len_loaded;

    logic             buf_free;
    logic             in_phase;
    logic             accept;
    logic             last_word;
    logic [4:0]       last_bytes;
    logic [7:0]       drop_bits;
    logic [127:0]     keep_mask;
    logic [127:0]     len_block;

    // The output register can take a new block when empty or being drained this cycle.
    assign buf_free   = !out_valid || out_ready;
    assign in_phase   = (state == S_AAD) || (state == S_CT);
    assign in_ready   = in_phase && buf_free;
    assign accept     = in_valid && in_ready;

    // On the final word of a phase only the first r bytes belong to the message.
    assign last_word  = (remaining <= CW'(16));
    assign last_bytes = last_word ? remaining[4:0] : 5'd16;
    assign drop_bits  = 8'd128 - {last_bytes, 3'b000};
    assign keep_mask  = {128{1'b1}} << drop_bits;

    assign len_block  = {(64'(aad_len) << 3), (64'(ct_len) << 3)};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and phase-decoded control outputs; start always restarts the sequence.
    always_comb begin
        state_nx    = state;
        ghash_start = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                state_nx = S_IDLE;
            end
            S_INIT: begin
                ghash_start = 1'b1;
                if (aad_len != '0) begin
                    state_nx = S_AAD;
                end else if (ct_len != '0) begin
                    state_nx = S_CT;
                end else begin
                    state_nx = S_LEN;
                end
            end
            S_AAD: begin
                if (accept && last_word) begin
                    state_nx = (ct_len != '0) ? S_CT : S_LEN;
                end
            end
            S_CT: begin
                if (accept && last_word) begin
                    state_nx = S_LEN;
                end
            end
            S_LEN: begin
                if (len_loaded && out_valid && out_ready) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (start) begin
            state_nx = S_INIT;
        end
    end

    // Length latches, per-phase byte counter and the single output buffer stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aad_len    <= '0;
            ct_len     <= '0;
            remaining  <= '0;
            len_loaded <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else if (start) begin
            aad_len    <= aad_bytes;
            ct_len     <= ct_bytes;
            remaining  <= '0;
            len_loaded <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    remaining  <= (aad_len != '0) ? CW'(aad_len) : CW'(ct_len);
                    len_loaded <= 1'b0;
                end
                S_AAD, S_CT: begin
                    if (accept) begin
                        if (!last_word) begin
                            remaining <= remaining - CW'(16);
                        end else if (state == S_AAD) begin
                            remaining <= CW'(ct_len);
                        end else begin
                            remaining <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (accept) begin
                out_data  <= in_data & keep_mask;
                out_valid <= 1'b1;
            end else if ((state == S_LEN) && !len_loaded && buf_free) begin
                out_data   <= len_block;
                out_valid  <= 1'b1;
                len_loaded <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ghash_block_formatter.sv
// tb/tb_ghash_block_formatter.sv - randomized self-checking bench for ghash_block_formatter
module tb_ghash_block_formatter;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  aad_bytes;
    logic [31:0]  ct_bytes;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ghash_start;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [127:0] got_q[$];

    ghash_block_formatter #(.LEN_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .aad_bytes   (aad_bytes),
        .ct_bytes    (ct_bytes),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ghash_start (ghash_start),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: keep message bytes 0..r-1 (byte 0 is the most significant), zero the rest.
    function automatic logic [127:0] keep_bytes(input logic [127:0] w, input int r);
        logic [127:0] o;
        o = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < r) o[127-8*b -: 8] = w[127-8*b -: 8];
        end
        return o;
    endfunction

    task automatic pulse_start(input int a, input int c);
        @(negedge clk);
        start     = 1'b1;
        aad_bytes = a;
        ct_bytes  = c;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        aad_bytes = $urandom;
        ct_bytes  = $urandom;
        #1;
        chk("ghash_start_pulse", ghash_start, 1);
        chk("busy_in_init", busy, 1);
        chk("out_valid_after_start", out_valid, 0);
    endtask

    // mode 0: continuous, 1: random valid/ready, 2: 3-cycle stall on first block, 3: all-0xFF words continuous
    task automatic run_msg(input int a, input int c, input int mode);
        logic [127:0] w[$];
        logic [127:0] exp_q[$];
        logic [127:0] prev_data;
        logic [127:0] pend_exp;
        logic         prev_stall;
        logic         pend;
        int na, nc, nw, idx, gs, dn, done_cyc, len_cyc, stall_left, r;
        na = (a + 15) / 16;
        nc = (c + 15) / 16;
        nw = na + nc;
        idx = 0; gs = 0; dn = 0; done_cyc = -1; len_cyc = -1; stall_left = 3;
        prev_stall = 1'b0; pend = 1'b0; prev_data = '0; pend_exp = '0;
        for (int i = 0; i < nw; i++) w.push_back((mode == 3) ? {128{1'b1}} : rnd128());
        for (int i = 0; i < na; i++) begin
            r = a - 16 * i;
            exp_q.push_back(keep_bytes(w[i], (r > 16) ? 16 : r));
        end
        for (int i = 0; i < nc; i++) begin
            r = c - 16 * i;
            exp_q.push_back(keep_bytes(w[na+i], (r > 16) ? 16 : r));
        end
        exp_q.push_back({64'(a) * 64'd8, 64'(c) * 64'd8});
        got_q.delete();

        pulse_start(a, c);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = (idx < nw) ? w[idx] : rnd128();
            if (mode == 1) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else if (mode == 2) begin
                if (out_valid && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (pend) begin
                chk("latency1_valid", out_valid, 1);
                chk("latency1_data", out_data, pend_exp);
                pend = 1'b0;
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (prev_stall) chk("stall_in_ready", in_ready, 0);
            if (ghash_start) gs++;
            if (done) begin
                dn++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (got_q.size() == nw + 1) len_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                if (idx < nw) begin
                    pend     = 1'b1;
                    pend_exp = exp_q[idx];
                end
                idx++;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk("busy_after_done", busy, 0);
                break;
            end
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("n_blocks", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("block", got_q[i], exp_q[i]);
        chk("words_consumed", idx, nw);
        chk("extra_ghash_start", gs, 0);
        chk("n_done", dn, 1);
        chk("done_after_len", done_cyc, len_cyc + 1);
    endtask

    initial begin
        int dn_pre;
        int seen;
        logic hit;
        reset = 1'b1; start = 1'b0; aad_bytes = '0; ct_bytes = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ghash_start", ghash_start, 0);
        @(negedge clk);
        reset = 1'b0;

        run_msg(16, 32, 0);
        if (got_q.size() == 4) chk("len_16_32", got_q[3], 128'h0000000000000080_0000000000000100);
        else chk("len_16_32_count", got_q.size(), 4);

        run_msg(20, 0, 3);
        if (got_q.size() == 3) begin
            chk("partial_ff", got_q[1], 128'hFFFFFFFF_00000000_00000000_00000000);
            chk("len_20_0", got_q[2], 128'h00000000000000A0_0000000000000000);
        end else chk("aad20_count", got_q.size(), 3);

        run_msg(0, 0, 0);
        if (got_q.size() == 1) chk("len_0_0", got_q[0], 0);
        else chk("empty_count", got_q.size(), 1);

        run_msg(0, 48, 2);

        // abort mid-ciphertext after one of three words
        pulse_start(0, 48);
        dn_pre = 0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b1;
            #1;
            if (done) dn_pre++;
            if (in_valid && in_ready) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_word_taken", hit, 1);
        @(posedge clk);
        #1;
        chk("abort_block_pending", out_valid, 1);
        run_msg(16, 16, 0);
        chk("abort_no_done", dn_pre, 0);

        // reset while the length block is waiting
        pulse_start(0, 0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b0;
        end
        #1;
        chk("len_pending_valid", out_valid, 1);
        chk("len_pending_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_ghash_start", ghash_start, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1;
            if (done || out_valid || busy) seen++;
        end
        chk("quiet_after_reset", seen, 0);

        for (int k = 0; k < 10; k++) begin
            run_msg($urandom_range(0, 70), $urandom_range(0, 70), (k % 2 == 0) ? 1 : 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
